// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encodings,
// opcodes and datapath mux/ALU select codes.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_FETCH     = 4'd1;
  localparam state_t ST_DECODE    = 4'd2;
  localparam state_t ST_MEM_ADDR  = 4'd3;
  localparam state_t ST_MEM_RD    = 4'd4;
  localparam state_t ST_MEM_WB    = 4'd5;
  localparam state_t ST_MEM_WR    = 4'd6;
  localparam state_t ST_R_EXEC    = 4'd7;
  localparam state_t ST_R_WB      = 4'd8;
  localparam state_t ST_BRANCH    = 4'd9;
  localparam state_t ST_JUMP      = 4'd10;
  localparam state_t ST_ADDI_EXEC = 4'd11;
  localparam state_t ST_ADDI_WB   = 4'd12;
  localparam state_t ST_ILLEGAL   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SL2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // States whose exit to FETCH marks a completed instruction.
  function automatic logic is_retire_state(state_t s);
    return (s == ST_MEM_WB) || (s == ST_MEM_WR) || (s == ST_R_WB) ||
           (s == ST_BRANCH) || (s == ST_JUMP) || (s == ST_ADDI_WB);
  endfunction

endpackage

// File: rtl/mc_retire_cnt.sv
// Retired-instruction counter: increments on inc_i, wraps naturally,
// synchronous active-low clear.
module mc_retire_cnt #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  output logic [CntWidth-1:0] count_o
);

  logic [CntWidth-1:0] count_d, count_q;

  // Next count: +1 when enabled, modulo 2^CntWidth.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + CntWidth'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit. Moore FSM over the IR opcode with a
// memory-ready handshake; FETCH qualifies ir_write/pc_write with i_mem_ready.
// Optional feature: define MC_CONTROL_ILLEGAL_TRAP_EN to trap unknown opcodes
// in a sticky ILLEGAL state (adds o_illegal); otherwise they retire as NOPs
// without counting.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [5:0]           i_opcode,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_pc_write,
  output logic                 o_pc_write_cond,
  output logic                 o_iord,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_ir_write,
  output logic                 o_mem_to_reg,
  output logic                 o_reg_dst,
  output logic                 o_reg_write,
  output logic                 o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_alu_op,
  output logic [1:0]           o_pc_source,
  output logic [3:0]           o_state,
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  output logic                 o_illegal,
`endif
  output logic [CNT_WIDTH-1:0] o_retired
);

  state_t state_d, state_q;
  logic   retire_inc;

  // The zero flag gates pc_write_cond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = i_zero;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (i_mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
          default:      state_d = ST_ILLEGAL;
`else
          default:      state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEM_ADDR:  state_d = (i_opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:    if (i_mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WR:    if (i_mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_FETCH;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      ST_ILLEGAL:   state_d = ST_ILLEGAL;
`endif
      default:      state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Count only completions; IDLE->FETCH and the NOP path from DECODE are excluded.
  assign retire_inc = (state_d == ST_FETCH) && is_retire_state(state_q);

  mc_retire_cnt #(
    .CntWidth(CNT_WIDTH)
  ) u_retire_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .inc_i  (retire_inc),
    .count_o(o_retired)
  );

  // Output decode from the current state (FETCH also looks at i_mem_ready).
  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_dst       = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_src_a     = 1'b0;
    o_alu_src_b     = ALU_SRC_B_RT;
    o_alu_op        = ALU_OP_ADD;
    o_pc_source     = PC_SRC_ALU;
    case (state_q)
      ST_FETCH: begin
        o_mem_read  = 1'b1;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
        o_alu_src_b = ALU_SRC_B_FOUR;
      end
      ST_DECODE: begin
        o_alu_src_b = ALU_SRC_B_IMM_SL2;
      end
      ST_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALU_SRC_B_IMM;
      end
      ST_MEM_RD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      ST_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      ST_R_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_op        = ALU_OP_SUB;
        o_pc_write_cond = 1'b1;
        o_pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = PC_SRC_JUMP;
      end
      ST_ADDI_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALU_SRC_B_IMM;
      end
      ST_ADDI_WB: begin
        o_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state = state_q;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  assign o_illegal = (state_q == ST_ILLEGAL);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a driver issues one directed vector per
// cycle and queues the expected state/controls/count; a negedge monitor
// pops and compares. Runs with CNT_WIDTH=4 so the 16-jump run wraps.
module tb_mc_control;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   opcode;
  logic         zero;
  logic         mem_ready;
  logic         pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic         mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]   alu_src_b, alu_op, pc_source;
  logic [3:0]   state;
  logic [W-1:0] retired;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic         illegal;
`endif

  typedef struct packed {
    logic [3:0]   st;
    logic [15:0]  ctrl;
    logic [W-1:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_control #(
    .CNT_WIDTH(W)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_opcode       (opcode),
    .i_zero         (zero),
    .i_mem_ready    (mem_ready),
    .o_pc_write     (pc_write),
    .o_pc_write_cond(pc_write_cond),
    .o_iord         (iord),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .o_ir_write     (ir_write),
    .o_mem_to_reg   (mem_to_reg),
    .o_reg_dst      (reg_dst),
    .o_reg_write    (reg_write),
    .o_alu_src_a    (alu_src_a),
    .o_alu_src_b    (alu_src_b),
    .o_alu_op       (alu_op),
    .o_pc_source    (pc_source),
    .o_state        (state),
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    .o_illegal      (illegal),
`endif
    .o_retired      (retired)
  );

  // Expected control word per state, straight from the state table.
  // Packing: {pw,pwc,iord,mr,mw,irw,m2r,rd,rw,sa,sb[1:0],op[1:0],ps[1:0]}
  function automatic logic [15:0] exp_ctrl(logic [3:0] st, logic rdy);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin mr = 1'b1; pw = rdy; irw = rdy; sb = 2'b01; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 1'b1; sb = 2'b10; end
      4'd4:  begin mr = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin sa = 1'b1; op = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
      4'd10: begin pw = 1'b1; ps = 2'b10; end
      4'd11: begin sa = 1'b1; sb = 2'b10; end
      4'd12: rw = 1'b1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT should show this cycle.
  task automatic step(logic rst, logic [5:0] op, logic z, logic rdy,
                      logic [3:0] st, int ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; opcode = op; zero = z; mem_ready = rdy;
    e.st   = st;
    e.ctrl = exp_ctrl(st, rdy);
    e.ret  = W'(ret);
    exp_q.push_back(e);
  endtask

  // Monitor: compare on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("ctrl", 32'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                         pc_source}), 32'(e.ctrl));
      check("retired", 32'(retired), 32'(e.ret));
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      check("illegal", 32'(illegal), 32'(e.st == 4'd13));
`endif
    end
  end

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    rst_n = 1'b0; opcode = R; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    // Reset still low on this edge: IDLE with everything zero.
    step(1, R, 0, 1, 4'd0, 0);
    // R-type
    step(1, R, 0, 1, 4'd1, 0);
    step(1, R, 0, 1, 4'd2, 0);
    step(1, R, 0, 1, 4'd7, 0);
    step(1, R, 0, 1, 4'd8, 0);
    // FETCH waits two cycles, then LW with three wait cycles in MEM_RD
    step(1, LW, 0, 0, 4'd1, 1);
    step(1, LW, 0, 0, 4'd1, 1);
    step(1, LW, 0, 1, 4'd1, 1);
    step(1, LW, 0, 1, 4'd2, 1);
    step(1, LW, 0, 1, 4'd3, 1);
    step(1, LW, 0, 0, 4'd4, 1);
    step(1, LW, 0, 0, 4'd4, 1);
    step(1, LW, 0, 0, 4'd4, 1);
    step(1, LW, 0, 1, 4'd4, 1);
    step(1, LW, 0, 1, 4'd5, 1);
    // BEQ with zero set
    step(1, BEQ, 1, 1, 4'd1, 2);
    step(1, BEQ, 1, 1, 4'd2, 2);
    step(1, BEQ, 1, 1, 4'd9, 2);
    // J
    step(1, J, 0, 1, 4'd1, 3);
    step(1, J, 0, 1, 4'd2, 3);
    step(1, J, 0, 1, 4'd10, 3);
    // ADDI
    step(1, ADDI, 0, 1, 4'd1, 4);
    step(1, ADDI, 0, 1, 4'd2, 4);
    step(1, ADDI, 0, 1, 4'd11, 4);
    step(1, ADDI, 0, 1, 4'd12, 4);
    // SW with one wait cycle in MEM_WR
    step(1, SW, 0, 1, 4'd1, 5);
    step(1, SW, 0, 1, 4'd2, 5);
    step(1, SW, 0, 1, 4'd3, 5);
    step(1, SW, 0, 0, 4'd6, 5);
    step(1, SW, 0, 1, 4'd6, 5);
    // Unknown opcode
    step(1, BAD, 0, 1, 4'd1, 6);
    step(1, BAD, 0, 1, 4'd2, 6);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) step(1, BAD, 0, 1, 4'd13, 6);
    step(0, BAD, 0, 1, 4'd13, 6);
`else
    step(0, BAD, 0, 1, 4'd1, 6);
`endif
    // Reset lands: count cleared
    step(1, SW, 0, 1, 4'd0, 0);
    step(1, SW, 0, 1, 4'd1, 0);
    step(1, SW, 0, 1, 4'd2, 0);
    step(1, SW, 0, 1, 4'd3, 0);
    step(1, SW, 0, 0, 4'd6, 0);
    // Reset during a stalled store: write must drop next cycle
    step(0, SW, 0, 0, 4'd6, 0);
    step(1, J, 0, 1, 4'd0, 0);
    // 16 jumps wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      step(1, J, 0, 1, 4'd1, i);
      step(1, J, 0, 1, 4'd2, i);
      step(1, J, 0, 1, 4'd10, i);
    end
    step(1, J, 0, 1, 4'd1, 16);
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
